ctrl_pipe_chain: RTL and testbench
==================================

Name: ctrl_pipe_chain

Overview:
Parametrised control-signal pipeline for the ID→EX→MEM→WB path. It carries a generic W-bit decoded control bundle through NSTAGE registered stages with per-stage valid and delay-slot bits. Stall propagates from downstream stages to upstream stages, and a bubble is inserted automatically behind a stalled stage. A built-in multicycle counter (HI/LO mul/div) generates the stall for EX and the stages before it. This block replaces the hand-written fixed-width control register chain in the controller.

Parameters:
- W, 32: control bundle width per stage
- NSTAGE, 4: number of stage registers (index 0 = D ... NSTAGE-1 = W)
- MC_STAGE, 1: stage index that owns multicycle ops (EX)
- CNT_W, 6: multicycle length counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  NSTAGE  per-stage external stall request
- flush  in  NSTAGE  per-stage flush (bubble insert)
- in_valid  in  1  decoded instruction valid into stage 0
- in_ctrl  in  W  decoded control bundle
- in_branch  in  1  instruction is branch/jump (next one is delay slot)
- mc_start  in  1  MC_STAGE instruction starts a multicycle op
- mc_len  in  CNT_W  extra cycles required
- out_ctrl  out  NSTAGE*W  flattened stage bundles, stage i at [i*W +: W]
- out_valid  out  NSTAGE  stage valid bits
- out_ds  out  NSTAGE  stage delay-slot bits
- stall_eff  out  NSTAGE  effective stall per stage (drives PC/IF hold)
- mc_busy  out  1  multicycle op in progress

Behaviour:
- Clock is clk; reset is synchronous and active-high. rst=1 on a clk edge clears out_ctrl, out_valid, out_ds, the counter, mc_busy and ds_pending to 0.
- Effective stall:
  - stall_eff[i] = stall[i] | stall_eff[i+1] | (mc_busy & i<=MC_STAGE).
  - The top stage uses stall[NSTAGE-1] only.
  - This logic is combinational.
- Stage i update, evaluated in priority order:
  1. flush[i]: load zero ctrl, valid=0, ds=0.
  2. stall_eff[i]: hold.
  3. i>0 and stall_eff[i-1]: load a bubble (zero ctrl, valid=0, ds=0).
  4. Otherwise: load stage i-1, or the inputs for i=0.
- Flush beats stall at the same stage. An unstalled stage 0 with in_valid=0 loads a bubble.
- Delay slot:
  - ds_pending is set when stage 0 accepts a valid instruction with in_branch=1.
  - The next valid instruction accepted into stage 0 gets ds=1 and clears ds_pending.
  - flush[0] clears ds_pending.
  - If a branch is accepted while ds_pending=1, it gets ds=1 and re-sets ds_pending.
- Multicycle counter:
  - Loads mc_len on a clk edge when mc_start=1, out_valid[MC_STAGE]=1, mc_busy=0, flush[MC_STAGE]=0, and mc_len≠0.
  - mc_busy = (cnt≠0). The counter decrements by 1 each cycle while nonzero.
  - mc_start with mc_len=0 produces no stall.
  - mc_start while busy is ignored.
  - flush[MC_STAGE] while busy clears cnt to 0; mc_busy drops the next cycle.
- Latency: one cycle per stage; the stage 0 input appears at stage k after k+1 unstalled edges.
- External stall beyond the last stage: stall[NSTAGE-1] holds the entire chain.

Optional Feature:
CTRL_PIPE_PERF_EN
- Defined: adds out ret_cnt[31:0] and bub_cnt[31:0].
  - ret_cnt counts edges where stage NSTAGE-1 holds valid=1 and is not stalled.
  - bub_cnt counts edges where any stage loads a bubble.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ctrl_pipe_pkg holds:
  - stage index constants STG_D=0, STG_E=1, STG_M=2, STG_W=3;
  - default W/CNT_W;
  - the ctrl bundle field-offset constants (RegWrite, MemRead, MemWrite, ALUControl, etc.) used by decoders.
- One sub-module, ctrl_stage_reg: a single W+2-bit stage register with flush/stall/bubble priority, generated NSTAGE times.

Test Plan:
- Reset: drive in_valid=1 and in_ctrl=32'hA5A5A5A5 with rst=1 for 2 cycles → all out_valid=0 and out_ctrl=0. Release rst → the value reaches stage 3 after 4 edges.
- Stall bubble: stall[1]=1 for 2 cycles with a stream 1,2,3 → stage 1 holds 2, stage 0 holds 3, stage 2 receives valid=0 for 2 cycles, and the stream resumes in order.
- Flush vs stall: stall[2]=1 and flush[2]=1 on the same edge → stage 2 valid=0 and ctrl=0; stages 0–1 held.
- Delay slot: branch accepted, then a 1-cycle bubble, then instr X → X carries ds=1 at every stage. A following instr Y has ds=0. Branch then flush[0] → the next instruction has ds=0.
- Multicycle: mc_start with mc_len=5 at stage 1 → mc_busy high for exactly 5 cycles, stall_eff[1:0]=2'b11, stage 2 gets 5 bubbles. mc_len=0 → no stall. flush[1] on busy cycle 2 → mc_busy low the next cycle.
- Perf (CTRL_PIPE_PERF_EN): 10 valid instructions with one 3-cycle stall[1] → ret_cnt=10, bub_cnt=3.

Source files
------------

// File: rtl/ctrl_pipe_chain_pkg.sv
// Shared constants for the ID->EX->MEM->WB control pipeline: stage indices,
// default widths and the bit layout of the decoded control bundle.
package ctrl_pipe_pkg;

  localparam int STG_D = 0;
  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  localparam int NUM_STAGES = 4;
  localparam int CTRL_W     = 32;
  localparam int MC_CNT_W   = 6;

  // Control bundle field offsets (bit position of the LSB of each field)
  localparam int CF_REG_WRITE  = 0;
  localparam int CF_MEM_TO_REG = 1;
  localparam int CF_MEM_READ   = 2;
  localparam int CF_MEM_WRITE  = 3;
  localparam int CF_BRANCH     = 4;
  localparam int CF_JUMP       = 5;
  localparam int CF_ALU_SRC    = 6;
  localparam int CF_REG_DST    = 7;
  localparam int CF_ALU_CTRL   = 8;
  localparam int CF_ALU_CTRL_W = 4;
  localparam int CF_HILO_WRITE = 12;
  localparam int CF_MULDIV     = 13;

  function automatic logic [CF_ALU_CTRL_W-1:0] alu_ctrl_of(input logic [CTRL_W-1:0] c);
    return c[CF_ALU_CTRL +: CF_ALU_CTRL_W];
  endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// Request/response bundle between the controller and the control pipeline.
// master drives stall/flush/decode inputs; slave (the pipeline) drives stage state.
interface ctrl_pipe_chain_if
  import ctrl_pipe_pkg::*;
#(
  parameter int W      = CTRL_W,
  parameter int NSTAGE = NUM_STAGES,
  parameter int CNT_W  = MC_CNT_W
);

  logic [NSTAGE-1:0]   stall;
  logic [NSTAGE-1:0]   flush;
  logic                in_valid;
  logic [W-1:0]        in_ctrl;
  logic                in_branch;
  logic                mc_start;
  logic [CNT_W-1:0]    mc_len;
  logic [NSTAGE*W-1:0] out_ctrl;
  logic [NSTAGE-1:0]   out_valid;
  logic [NSTAGE-1:0]   out_ds;
  logic [NSTAGE-1:0]   stall_eff;
  logic                mc_busy;

  modport master (
    output stall, flush, in_valid, in_ctrl, in_branch, mc_start, mc_len,
    input  out_ctrl, out_valid, out_ds, stall_eff, mc_busy
  );

  modport slave (
    input  stall, flush, in_valid, in_ctrl, in_branch, mc_start, mc_len,
    output out_ctrl, out_valid, out_ds, stall_eff, mc_busy
  );

endinterface

// File: rtl/ctrl_pipe_chain_stage.sv
// One control pipeline stage register {valid, ds, ctrl} with
// flush > hold > bubble > load priority.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int W = CTRL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic         valid_i,
  input  logic         ds_i,
  input  logic [W-1:0] ctrl_i,
  output logic         valid_o,
  output logic         ds_o,
  output logic [W-1:0] ctrl_o
);

  logic [W+1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush_i)       stage_d = '0;
    else if (hold_i)   stage_d = stage_q;
    else if (bubble_i) stage_d = '0;
    else               stage_d = {valid_i, ds_i, ctrl_i};
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign {valid_o, ds_o, ctrl_o} = stage_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Parametrised control-bundle pipeline with stall back-propagation, automatic
// bubbles, delay-slot tagging and a multicycle stall counter.
// Optional: define CTRL_PIPE_PERF_EN to add ret_cnt/bub_cnt performance counters.
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int W        = CTRL_W,
  parameter int NSTAGE   = NUM_STAGES,
  parameter int MC_STAGE = STG_E,
  parameter int CNT_W    = MC_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  ctrl_pipe_chain_if.slave  bus
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]       ret_cnt,
  output logic [31:0]       bub_cnt
`endif
);

  logic [NSTAGE-1:0]         stall_eff;
  logic [NSTAGE:0]           se_chain;
  logic [NSTAGE-1:0][W-1:0]  q_ctrl;
  logic [NSTAGE-1:0]         q_valid;
  logic [NSTAGE-1:0]         q_ds;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      mc_busy;
  logic                      mc_load;
  logic                      ds_pending_q, ds_pending_d;
  logic                      accept0;

  assign mc_busy = (cnt_q != '0);

  // Stall ripples from the last stage back towards stage 0.
  always_comb begin
    se_chain = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      se_chain[i] = bus.stall[i] | se_chain[i+1] | (mc_busy & (i <= MC_STAGE));
    end
    stall_eff = se_chain[NSTAGE-1:0];
  end

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    logic         bub;
    logic         dv;
    logic         dd;
    logic [W-1:0] dc;

    if (i == 0) begin : g_head
      assign bub = 1'b0;
      assign dv  = bus.in_valid;
      assign dd  = bus.in_valid & ds_pending_q;
      assign dc  = bus.in_valid ? bus.in_ctrl : '0;
    end else begin : g_body
      assign bub = stall_eff[i-1];
      assign dv  = q_valid[i-1];
      assign dd  = q_ds[i-1];
      assign dc  = q_ctrl[i-1];
    end

    ctrl_stage_reg #(.W(W)) u_reg (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (bus.flush[i]),
      .hold_i   (stall_eff[i]),
      .bubble_i (bub),
      .valid_i  (dv),
      .ds_i     (dd),
      .ctrl_i   (dc),
      .valid_o  (q_valid[i]),
      .ds_o     (q_ds[i]),
      .ctrl_o   (q_ctrl[i])
    );
  end

  // Any accepted instruction consumes the pending slot; a branch re-arms it.
  assign accept0 = ~bus.flush[0] & ~stall_eff[0] & bus.in_valid;

  always_comb begin
    ds_pending_d = ds_pending_q;
    if (bus.flush[0])  ds_pending_d = 1'b0;
    else if (accept0)  ds_pending_d = bus.in_branch;
  end

  assign mc_load = bus.mc_start & q_valid[MC_STAGE] & ~mc_busy &
                   ~bus.flush[MC_STAGE] & (bus.mc_len != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (mc_load)                 cnt_d = bus.mc_len;
    else if (bus.flush[MC_STAGE]) cnt_d = '0;
    else if (mc_busy)            cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      ds_pending_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ds_pending_q <= ds_pending_d;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]       ret_q, bub_q;
  logic [NSTAGE-1:0] bub_load;

  // Only automatic bubbles count, not drained-through empty slots.
  assign bub_load = ~bus.flush & ~stall_eff & {stall_eff[NSTAGE-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q <= '0;
      bub_q <= '0;
    end else begin
      if (q_valid[NSTAGE-1] & ~stall_eff[NSTAGE-1]) ret_q <= ret_q + 32'd1;
      if (|bub_load)                                 bub_q <= bub_q + 32'd1;
    end
  end

  assign ret_cnt = ret_q;
  assign bub_cnt = bub_q;
`endif

  assign bus.out_ctrl  = q_ctrl;
  assign bus.out_valid = q_valid;
  assign bus.out_ds    = q_ds;
  assign bus.stall_eff = stall_eff;
  assign bus.mc_busy   = mc_busy;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain: vector table, directed corner
// sequences and random traffic against a behavioural model.
module tb_ctrl_pipe_chain;
  import ctrl_pipe_pkg::*;

  localparam int W  = 32;
  localparam int NS = 4;
  localparam int MC = STG_E;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_chain_if #(.W(W), .NSTAGE(NS), .CNT_W(CW)) bus();

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] ret_cnt, bub_cnt;
`endif

  ctrl_pipe_chain #(.W(W), .NSTAGE(NS), .MC_STAGE(MC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .ret_cnt (ret_cnt),
    .bub_cnt (bub_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [NS*W-1:0] act, input logic [NS*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: an array of instruction slots plus a cycles-left count.
  logic           m_v   [NS];
  logic           m_ds  [NS];
  logic [W-1:0]   m_c   [NS];
  int             m_cnt = 0;
  logic           m_dsp;
  logic [31:0]    m_ret, m_bub;

  function automatic logic [NS-1:0] model_stall();
    logic [NS-1:0] s;
    logic          downstream;
    downstream = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      downstream = downstream | bus.stall[i] | ((m_cnt > 0) && (i <= MC));
      s[i] = downstream;
    end
    return s;
  endfunction

  function automatic logic [NS-1:0] m_vvec();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = m_v[i];
    return r;
  endfunction

  function automatic logic [NS-1:0] m_dsvec();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = m_ds[i];
    return r;
  endfunction

  function automatic logic [NS*W-1:0] m_flat();
    logic [NS*W-1:0] r;
    for (int i = 0; i < NS; i++) r[i*W +: W] = m_c[i];
    return r;
  endfunction

  task automatic model_edge();
    logic [NS-1:0] se;
    logic          start_ok, any_bub;
    se = model_stall();
    if (rst) begin
      for (int i = 0; i < NS; i++) begin m_v[i] = 0; m_ds[i] = 0; m_c[i] = '0; end
      m_cnt = 0; m_dsp = 0; m_ret = 0; m_bub = 0;
      return;
    end
    start_ok = bus.mc_start && m_v[MC] && (m_cnt == 0) && !bus.flush[MC] && (bus.mc_len != 0);
    if (m_v[NS-1] && !se[NS-1]) m_ret++;
    any_bub = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (bus.flush[i]) begin
        m_v[i] = 0; m_ds[i] = 0; m_c[i] = '0;
      end else if (se[i]) begin
        // slot keeps its instruction
      end else if (i > 0 && se[i-1]) begin
        m_v[i] = 0; m_ds[i] = 0; m_c[i] = '0; any_bub = 1;
      end else if (i > 0) begin
        m_v[i] = m_v[i-1]; m_ds[i] = m_ds[i-1]; m_c[i] = m_c[i-1];
      end else if (bus.in_valid) begin
        m_v[0] = 1; m_ds[0] = m_dsp; m_c[0] = bus.in_ctrl;
        m_dsp = bus.in_branch;
      end else begin
        m_v[0] = 0; m_ds[0] = 0; m_c[0] = '0;
      end
    end
    if (bus.flush[0]) m_dsp = 0;
    if (any_bub) m_bub++;
    if (start_ok)          m_cnt = int'(bus.mc_len);
    else if (bus.flush[MC]) m_cnt = 0;
    else if (m_cnt > 0)     m_cnt--;
  endtask

  task automatic idle();
    bus.stall = '0; bus.flush = '0; bus.in_valid = 0; bus.in_ctrl = '0;
    bus.in_branch = 0; bus.mc_start = 0; bus.mc_len = '0;
  endtask

  task automatic feed(input logic [W-1:0] c, input logic br);
    idle();
    bus.in_valid = 1; bus.in_ctrl = c; bus.in_branch = br;
  endtask

  // Inputs are applied by the caller just after a rising edge.
  task automatic tick();
    @(negedge clk);
    chk("stall_eff", bus.stall_eff, model_stall());
    chk("mc_busy", bus.mc_busy, (m_cnt > 0));
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", bus.out_valid, m_vvec());
    chk("out_ds", bus.out_ds, m_dsvec());
    chk("out_ctrl", bus.out_ctrl, m_flat());
`ifdef CTRL_PIPE_PERF_EN
    chk("ret_cnt", ret_cnt, m_ret);
    chk("bub_cnt", bub_cnt, m_bub);
`endif
  endtask

  typedef struct {
    logic               iv;
    logic [7:0]         ic;
    logic [NS-1:0]      st;
    logic [NS-1:0]      fl;
    logic [NS-1:0]      ev;
    logic [NS-1:0][7:0] ec;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 8'd1, 4'b0000, 4'b0000, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd1}};
    tbl[1]  = '{1'b1, 8'd2, 4'b0000, 4'b0000, 4'b0011, {8'd0, 8'd0, 8'd1, 8'd2}};
    tbl[2]  = '{1'b1, 8'd3, 4'b0000, 4'b0000, 4'b0111, {8'd0, 8'd1, 8'd2, 8'd3}};
    tbl[3]  = '{1'b1, 8'd4, 4'b0010, 4'b0000, 4'b1011, {8'd1, 8'd0, 8'd2, 8'd3}};
    tbl[4]  = '{1'b1, 8'd4, 4'b0010, 4'b0000, 4'b0011, {8'd0, 8'd0, 8'd2, 8'd3}};
    tbl[5]  = '{1'b1, 8'd4, 4'b0000, 4'b0000, 4'b0111, {8'd0, 8'd2, 8'd3, 8'd4}};
    tbl[6]  = '{1'b1, 8'd5, 4'b0000, 4'b0000, 4'b1111, {8'd2, 8'd3, 8'd4, 8'd5}};
    tbl[7]  = '{1'b1, 8'd6, 4'b0100, 4'b0100, 4'b0011, {8'd0, 8'd0, 8'd4, 8'd5}};
    tbl[8]  = '{1'b1, 8'd6, 4'b0000, 4'b0000, 4'b0111, {8'd0, 8'd4, 8'd5, 8'd6}};
    tbl[9]  = '{1'b1, 8'd7, 4'b1000, 4'b0000, 4'b0111, {8'd0, 8'd4, 8'd5, 8'd6}};
    tbl[10] = '{1'b1, 8'd7, 4'b0000, 4'b0001, 4'b1110, {8'd4, 8'd5, 8'd6, 8'd0}};
    tbl[11] = '{1'b0, 8'd0, 4'b0000, 4'b0000, 4'b1100, {8'd5, 8'd6, 8'd0, 8'd0}};

    // Reset while an instruction is presented
    idle();
    rst = 1; bus.in_valid = 1; bus.in_ctrl = 32'hA5A5A5A5;
    @(posedge clk); #1;
    model_edge();
    tick();
    chk("rst_valid", bus.out_valid, 4'b0000);
    chk("rst_ctrl", bus.out_ctrl, '0);
    chk("rst_busy", bus.mc_busy, 1'b0);
    rst = 0;
    tick();
    idle();
    repeat (3) tick();
    chk("lat_valid3", bus.out_valid[3], 1'b1);
    chk("lat_ctrl3", bus.out_ctrl[3*W +: W], 32'hA5A5A5A5);
    repeat (4) tick();

    // Stall bubble / flush-vs-stall / whole-chain hold table
    for (int k = 0; k < 12; k++) begin
      idle();
      bus.in_valid = tbl[k].iv; bus.in_ctrl = {24'd0, tbl[k].ic};
      bus.stall = tbl[k].st; bus.flush = tbl[k].fl;
      tick();
      chk($sformatf("tbl%0d_valid", k), bus.out_valid, tbl[k].ev);
      for (int i = 0; i < NS; i++)
        chk($sformatf("tbl%0d_ctrl%0d", k, i), bus.out_ctrl[i*W +: W], {24'd0, tbl[k].ec[i]});
    end

    // Delay slot across a bubble
    feed(32'hB0, 1); tick();
    idle(); tick();
    feed(32'hC1, 0); tick();
    chk("ds_x_s0", bus.out_ds[0], 1'b1);
    feed(32'hC2, 0); tick();
    chk("ds_x_s1", bus.out_ds[1], 1'b1);
    chk("ds_y_s0", bus.out_ds[0], 1'b0);
    idle(); tick();
    chk("ds_x_s2", bus.out_ds[2], 1'b1);
    chk("ds_y_s1", bus.out_ds[1], 1'b0);
    tick();
    chk("ds_x_s3", bus.out_ds[3], 1'b1);
    chk("ds_y_s2", bus.out_ds[2], 1'b0);
    // Branch then flush[0] cancels the slot
    feed(32'hD0, 1); tick();
    idle(); bus.flush = 4'b0001; tick();
    feed(32'hD1, 0); tick();
    chk("ds_flush_v", bus.out_valid[0], 1'b1);
    chk("ds_flush_ds", bus.out_ds[0], 1'b0);
    // Branch in a delay slot
    feed(32'hE0, 1); tick();
    feed(32'hE1, 1); tick();
    chk("ds_br_in_slot", bus.out_ds[0], 1'b1);
    feed(32'hE2, 0); tick();
    chk("ds_after_br2", bus.out_ds[0], 1'b1);
    feed(32'hE3, 0); tick();
    chk("ds_cleared", bus.out_ds[0], 1'b0);
    idle(); repeat (4) tick();

    // Multicycle length 5
    feed(32'h40, 0); tick();
    feed(32'h41, 0); tick();
    idle(); bus.mc_start = 1; bus.mc_len = 6'd5; tick();
    chk("mc_busy_e0", bus.mc_busy, 1'b1);
    chk("mc_se_e0", bus.stall_eff, 4'b0011);
    chk("mc_instr_s2", bus.out_ctrl[2*W +: W], 32'h40);
    idle();
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("mc_bubble%0d", k), bus.out_valid[2], 1'b0);
      chk($sformatf("mc_busy%0d", k), bus.mc_busy, (k < 5));
      chk($sformatf("mc_se%0d", k), bus.stall_eff, (k < 5) ? 4'b0011 : 4'b0000);
    end
    chk("mc_held_s1", bus.out_ctrl[1*W +: W], 32'h41);
    // Zero length: no stall
    idle(); bus.mc_start = 1; bus.mc_len = 6'd0; tick();
    chk("mc0_busy", bus.mc_busy, 1'b0);
    chk("mc0_se", bus.stall_eff, 4'b0000);
    // Flush of the owning stage aborts the count
    feed(32'h50, 0); tick();
    feed(32'h51, 0); tick();
    idle(); bus.mc_start = 1; bus.mc_len = 6'd5; tick();
    idle(); tick();
    chk("mcf_busy1", bus.mc_busy, 1'b1);
    bus.flush = 4'b0010; tick();
    chk("mcf_busy_drop", bus.mc_busy, 1'b0);
    chk("mcf_se", bus.stall_eff, 4'b0000);
    idle(); repeat (4) tick();

`ifdef CTRL_PIPE_PERF_EN
    idle(); rst = 1; tick(); rst = 0;
    for (int k = 1; k <= 5; k++) begin feed(k, 0); tick(); end
    feed(6, 0); bus.stall = 4'b0010;
    repeat (3) tick();
    for (int k = 6; k <= 10; k++) begin feed(k, 0); tick(); end
    idle(); repeat (6) tick();
    chk("perf_ret", ret_cnt, 32'd10);
    chk("perf_bub", bub_cnt, 32'd3);
`endif

    // Random traffic against the model
    idle(); rst = 1; tick(); rst = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NS; i++) begin
        bus.stall[i] = ($urandom_range(0, 9) == 0);
        bus.flush[i] = ($urandom_range(0, 15) == 0);
      end
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_ctrl   = $urandom;
      bus.in_branch = ($urandom_range(0, 3) == 0);
      bus.mc_start  = ($urandom_range(0, 4) == 0);
      bus.mc_len    = CW'($urandom_range(0, 7));
      rst           = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; idle(); repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
